nanov_serial_muldiv: RTL and testbench

Parametrised bit-serial RV32M execution unit for the nanoV family. It supersedes the fixed-width, multiply-only helper and adds the full M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, with RISC-V divide-by-zero and overflow semantics. Operands enter LSB-first one bit per cycle, in step with the core's register bit stream. The result leaves LSB-first over XLEN cycles with a valid/last strobe.

---
 rtl/nanov_muldiv_pkg.sv | 53 +++++
 rtl/nanov_serial_negate.sv | 30 +++
 rtl/nanov_serial_muldiv.sv | 185 ++++++++++++++++++
 tb/tb_nanov_serial_muldiv.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanov_muldiv_pkg.sv
// Shared definitions for the nanoV bit-serial RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operation-decode helpers.
package nanov_muldiv_pkg;

    // RISC-V M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFix,
        StCalc,
        StOut
    } state_e;

    // Any of the four divide-family operations
    function automatic logic is_div(input logic [2:0] f3);
        return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    // Remainder operations return the remainder rather than the quotient
    function automatic logic is_rem(input logic [2:0] f3);
        return f3 inside {F3_REM, F3_REMU};
    endfunction

    // Operand A is interpreted as two's complement
    function automatic logic a_signed(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    // Operand B is interpreted as two's complement
    function automatic logic b_signed(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_DIV, F3_REM};
    endfunction

    // Multiplies returning the upper half of the double-width product
    function automatic logic high_half(input logic [2:0] f3);
        return f3 inside {F3_MULH, F3_MULHSU, F3_MULHU};
    endfunction

    // Result comes from the upper half of the accumulator (MULH* product or remainder)
    function automatic logic sel_high(input logic [2:0] f3);
        return high_half(f3) | is_rem(f3);
    endfunction

endpackage

// File: rtl/nanov_serial_negate.sv
// Bit-serial conditional two's-complement negator. Bits arrive LSB first;
// when neg_i is set each bit is inverted and the running +1 carry added.
module nanov_serial_negate (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic init_i,
    input  logic carry_init_i,
    input  logic en_i,
    input  logic neg_i,
    input  logic bit_i,
    output logic bit_o
);

    logic carry_q;

    // ~x + carry, one bit at a time; pass-through when not negating
    assign bit_o = neg_i ? (~bit_i ^ carry_q) : bit_i;

    // Carry loads its start value, then ripples while bits stream through
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            carry_q <= 1'b0;
        end else if (init_i) begin
            carry_q <= carry_init_i;
        end else if (en_i) begin
            carry_q <= carry_q & ~bit_i;
        end
    end

endmodule

// File: rtl/nanov_serial_muldiv.sv
// Bit-serial RV32M execution unit. Operands stream in LSB first, are turned
// into magnitudes, processed with one shift-add or restoring-divide step per
// cycle, and the result streams out LSB first with sign applied serially.
module nanov_serial_muldiv
    import nanov_muldiv_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_BITS = 5
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       start_i,
    input  logic [2:0] funct3_i,
    input  logic       rs1_bit_i,
    input  logic       rs2_bit_i,
    input  logic       flush_i,
    output logic       busy_o,
    output logic       out_valid_o,
    output logic       out_bit_o,
    output logic       out_last_o
);

    localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(XLEN - 1);
    localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

    state_e                state_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic [2:0]            f3_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    // Shared accumulator: multiply {product hi, multiplier/product lo},
    // divide {remainder, dividend/quotient}
    logic [2*XLEN-1:0]     acc_q;
    logic                  neg_q;
    logic                  out_valid_q;
    logic                  out_bit_q;
    logic                  out_last_q;

    logic                  sign_a;
    logic                  sign_b;
    logic [XLEN-1:0]       mag_a;
    logic [XLEN-1:0]       mag_b;
    logic                  div_zero;
    logic                  neg_res;
    logic [XLEN:0]         add_sum;
    logic [2*XLEN-1:0]     mul_next;
    logic [XLEN:0]         rem_shift;
    logic [XLEN:0]         diff;
    logic [2*XLEN-1:0]     div_next;
    logic [2*XLEN-1:0]     calc_next;
    logic                  raw_bit;
    logic                  neg_bit;
    logic                  carry_init;
    logic                  neg_init;
    logic                  neg_en;

    // Sign fix-up, arithmetic step and output bit selection
    always_comb begin
        sign_a   = a_signed(f3_q) & a_q[XLEN-1];
        sign_b   = b_signed(f3_q) & b_q[XLEN-1];
        mag_a    = sign_a ? -a_q : a_q;
        mag_b    = sign_b ? -b_q : b_q;
        div_zero = (b_q == '0);
        neg_res  = is_rem(f3_q) ? sign_a : (sign_a ^ sign_b);
        // DIV by zero must yield all ones regardless of dividend sign
        if (div_zero && (f3_q == F3_DIV)) begin
            neg_res = 1'b0;
        end

        // Shift-add multiply step
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_next = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]}
                            : {1'b0, acc_q[2*XLEN-1:1]};

        // Restoring divide step; quotient bits enter at the bottom
        rem_shift = acc_q[2*XLEN-1:XLEN-1];
        diff      = rem_shift - {1'b0, b_q};
        div_next  = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        calc_next = is_div(f3_q) ? div_next : mul_next;

        // Low half is shifted out alongside the high half, so both stay at bit 0 / XLEN
        raw_bit    = sel_high(f3_q) ? acc_q[XLEN] : acc_q[0];
        // Negating the upper half only carries in if the whole lower half was zero
        carry_init = high_half(f3_q) ? (calc_next[XLEN-1:0] == '0) : 1'b1;
        neg_init   = (state_q == StCalc) && (cnt_q == CntMax);
        neg_en     = (state_q == StOut) && !out_last_q;
    end

    nanov_serial_negate u_negate (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .init_i       (neg_init),
        .carry_init_i (carry_init),
        .en_i         (neg_en),
        .neg_i        (neg_q),
        .bit_i        (raw_bit),
        .bit_o        (neg_bit)
    );

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            f3_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (flush_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        f3_q    <= funct3_i;
                        a_q     <= {rs1_bit_i, a_q[XLEN-1:1]};
                        b_q     <= {rs2_bit_i, b_q[XLEN-1:1]};
                        cnt_q   <= CntOne;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    a_q <= {rs1_bit_i, a_q[XLEN-1:1]};
                    b_q <= {rs2_bit_i, b_q[XLEN-1:1]};
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StFix: begin
                    b_q     <= mag_b;
                    acc_q   <= {{XLEN{1'b0}}, mag_a};
                    neg_q   <= neg_res;
                    state_q <= StCalc;
                end
                StCalc: begin
                    acc_q <= calc_next;
                    if (cnt_q == CntMax) begin
                        cnt_q   <= '0;
                        state_q <= StOut;
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StOut: begin
                    if (out_last_q) begin
                        // Last bit has been presented for a full cycle
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        out_bit_q   <= 1'b0;
                        out_last_q  <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_bit_q   <= neg_bit;
                        out_last_q  <= (cnt_q == CntMax);
                        cnt_q       <= cnt_q + CntOne;
                        acc_q       <= {1'b0, acc_q[2*XLEN-1:1]};
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = out_valid_q;
    assign out_bit_o   = out_bit_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_nanov_serial_muldiv.sv
// Directed/random bench for the serial mul/div unit at XLEN=32 and XLEN=16.
module tb_nanov_serial_muldiv;

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          sedge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       flush = 1'b0;
    logic       s32_start = 1'b0, s16_start = 1'b0;
    logic [2:0] s32_f3 = '0, s16_f3 = '0;
    logic       s32_a = 1'b0, s32_b = 1'b0, s16_a = 1'b0, s16_b = 1'b0;
    logic       busy32, val32, bit32, last32;
    logic       busy16, val16, bit16, last16;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   valid_seen32 = 0;
    bit   ign32 = 1'b0;
    exp_t q32[$];
    exp_t q16[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nanov_serial_muldiv #(.XLEN(32), .CNT_BITS(5)) u_dut32 (
        .clk_i(clk), .rstn_i(rstn), .start_i(s32_start), .funct3_i(s32_f3),
        .rs1_bit_i(s32_a), .rs2_bit_i(s32_b), .flush_i(flush),
        .busy_o(busy32), .out_valid_o(val32), .out_bit_o(bit32), .out_last_o(last32)
    );

    nanov_serial_muldiv #(.XLEN(16), .CNT_BITS(4)) u_dut16 (
        .clk_i(clk), .rstn_i(rstn), .start_i(s16_start), .funct3_i(s16_f3),
        .rs1_bit_i(s16_a), .rs2_bit_i(s16_b), .flush_i(flush),
        .busy_o(busy16), .out_valid_o(val16), .out_bit_o(bit16), .out_last_o(last16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent RV32M reference
    function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive(input bit w16, input logic st, input logic [2:0] f,
                         input logic ab, input logic bb);
        if (w16) begin
            s16_start = st; s16_f3 = f; s16_a = ab; s16_b = bb;
        end else begin
            s32_start = st; s32_f3 = f; s32_a = ab; s32_b = bb;
        end
    endtask

    // mode 0: normal, 1: flush mid-CALC, 2: async reset mid-OUT. Called at a negedge.
    task automatic run_op(input bit w16, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input string tag,
                          input int mode, input bit pulse);
        int   w;
        int   j;
        logic bz;
        exp_t e;
        w = w16 ? 16 : 32;
        e.tag = tag; e.val = expv; e.sedge = cyc + 1;
        if (mode == 0) begin
            if (w16) q16.push_back(e); else q32.push_back(e);
        end
        if (mode == 2) ign32 = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) drive(w16, 1'b1, f3, a[i], b[i]);
            else        drive(w16, pulse && (i == 3), f3 ^ 3'b101, a[i], b[i]);
        end
        @(negedge clk);
        drive(w16, 1'b0, f3, 1'b0, 1'b0);
        for (j = 0; j < 4 * w; j++) begin
            bz = w16 ? busy16 : busy32;
            if (!bz) break;
            if (mode == 1 && j == w / 2) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                chk({tag, "_flush_busy"}, 32'(busy32), 0);
                break;
            end
            if (mode == 2 && j == w + 5) begin
                chk({tag, "_pre_reset"}, {30'b0, val32, bit32}, 32'h3);
                #3 rstn = 1'b0;
                #1 chk({tag, "_async_reset"}, {28'b0, busy32, val32, bit32, last32}, 0);
                @(negedge clk);
                @(negedge clk);
                rstn = 1'b1;
                ign32 = 1'b0;
                break;
            end
            drive(w16, pulse && (j == w / 2 || j == w + 5), f3 ^ 3'b101,
                  1'($urandom), 1'($urandom));
            @(negedge clk);
        end
        drive(w16, 1'b0, f3, 1'b0, 1'b0);
        if (mode == 0) chk({tag, "_busy_len"}, j, 2 * w + 2);
    endtask

    // Output collector for the 32-bit instance
    initial begin
        logic [31:0] acc = '0;
        int          n = 0;
        bit          lastp = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rstn || ign32) begin
                n = 0; lastp = 1'b0; acc = '0;
            end else begin
                if (lastp) begin
                    chk("idle_after_last32", {30'b0, busy32, val32}, 0);
                    lastp = 1'b0;
                end
                if (val32) begin
                    valid_seen32++;
                    if (n == 0) begin
                        chk("out_expected32", 32'(q32.size() != 0), 1);
                        if (q32.size() != 0)
                            chk({q32[0].tag, "_first_valid"}, cyc - q32[0].sedge, 2 * 32 + 1);
                    end
                    if (n < 32) acc[n] = bit32;
                    n++;
                    if (last32 || n == 32) begin
                        chk("last_pos32", n, 32);
                        chk("last_flag32", 32'(last32), 1);
                        if (q32.size() != 0) begin
                            e = q32.pop_front();
                            chk(e.tag, acc, e.val);
                        end
                        n = 0; lastp = 1'b1; acc = '0;
                    end
                end
            end
        end
    end

    // Output collector for the 16-bit instance
    initial begin
        logic [31:0] acc = '0;
        int          n = 0;
        bit          lastp = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                n = 0; lastp = 1'b0; acc = '0;
            end else begin
                if (lastp) begin
                    chk("idle_after_last16", {30'b0, busy16, val16}, 0);
                    lastp = 1'b0;
                end
                if (val16) begin
                    if (n == 0) begin
                        chk("out_expected16", 32'(q16.size() != 0), 1);
                        if (q16.size() != 0)
                            chk({q16[0].tag, "_first_valid"}, cyc - q16[0].sedge, 2 * 16 + 1);
                    end
                    if (n < 16) acc[n] = bit16;
                    n++;
                    if (last16 || n == 16) begin
                        chk("last_pos16", n, 16);
                        chk("last_flag16", 32'(last16), 1);
                        if (q16.size() != 0) begin
                            e = q16.pop_front();
                            chk(e.tag, acc, e.val);
                        end
                        n = 0; lastp = 1'b1; acc = '0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          seen;

        repeat (2) @(negedge clk);
        chk("reset32", {28'b0, busy32, val32, bit32, last32}, 0);
        chk("reset16", {28'b0, busy16, val16, bit16, last16}, 0);
        rstn = 1'b1;
        @(negedge clk);

        run_op(0, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul",      0, 0);
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh",     0, 0);
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu",    0, 0);
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu",   0, 0);
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div",      0, 0);
        run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem",      0, 0);
        run_op(0, 3'd5, 32'd100,       32'd7,         32'd14,        "divu",     0, 0);
        run_op(0, 3'd7, 32'd100,       32'd7,         32'd2,         "remu",     0, 0);
        run_op(0, 3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_z",    0, 0);
        run_op(0, 3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "divn_z",   0, 0);
        run_op(0, 3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "remn_z",   0, 0);
        run_op(0, 3'd7, 32'd5,         32'd0,         32'd5,         "remu_z",   0, 0);
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf",  0, 0);
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         "rem_ovf",  0, 0);

        // Start pulses during LOAD, CALC and OUT must not disturb the operation
        run_op(0, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_pls",  0, 1);
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_pls",  0, 1);

        for (int k = 0; k < 8; k++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (k % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(0, f, a, b, ref32(f, a, b), $sformatf("rand%0d_f%0d", k, f), 0, 0);
        end

        // Flush mid-CALC: no output may ever appear
        seen = valid_seen32;
        run_op(0, 3'd0, 32'd3, 32'd5, 32'd15, "flush", 1, 0);
        repeat (3 * 32 + 5) @(negedge clk);
        chk("flush_no_output", valid_seen32 - seen, 0);

        // Flush and start together in IDLE: start is dropped
        drive(0, 1'b1, 3'd0, 1'b1, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("flush_start_drop", 32'(busy32), 0);
        repeat (3) @(negedge clk);
        chk("flush_start_idle", 32'(busy32), 0);

        // Asynchronous reset during OUT, then normal operation resumes
        run_op(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "rst", 2, 0);
        @(negedge clk);
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "post_rst_mulhu", 0, 0);
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "post_rst_div",   0, 0);

        // 16-bit instance
        run_op(1, 3'd0, 32'd7,      32'hFFFD, 32'hFFEB, "mul16",     0, 0);
        run_op(1, 3'd1, 32'h8000,   32'h8000, 32'h4000, "mulh16",    0, 0);
        run_op(1, 3'd4, 32'hFFF9,   32'd2,    32'hFFFD, "div16",     0, 0);
        run_op(1, 3'd6, 32'hFFF9,   32'd2,    32'hFFFF, "rem16",     0, 0);
        run_op(1, 3'd5, 32'd100,    32'd7,    32'd14,   "divu16",    0, 0);
        run_op(1, 3'd4, 32'd5,      32'd0,    32'hFFFF, "div_z16",   0, 0);
        run_op(1, 3'd4, 32'h8000,   32'hFFFF, 32'h8000, "div_ovf16", 0, 0);
        run_op(1, 3'd0, 32'd7,      32'hFFFD, 32'hFFEB, "mul16_pls", 0, 1);

        repeat (4) @(negedge clk);
        chk("q32_drained", q32.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
